// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencing
// over a single req/ack memory port, with sticky trap flags and an instret counter.
module multicycle_control_fsm #(
  parameter int unsigned ALU_W       = 4,
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  input  logic              BrEq,
  input  logic              BrLt,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic              mem_unsigned,
  output logic [31:0]       Inst,
  output logic              IRWrite,
  output logic              PCWrite,
  output logic              PCSel,
  output logic [2:0]        ImmSel,
  output logic              ASel,
  output logic              BSel,
  output logic [ALU_W-1:0]  ALUSel,
  output logic              BrUn,
  output logic              RegWriteEnable,
  output logic [1:0]        WBSel,
  output logic              illegal_inst,
  output logic              bus_error,
  output logic [CNT_W-1:0]  instret
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_TRAP
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMATH  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [ALU_W-1:0] ALU_ADD   = ALU_W'(0);
  localparam logic [ALU_W-1:0] ALU_SUB   = ALU_W'(1);
  localparam logic [ALU_W-1:0] ALU_XOR   = ALU_W'(2);
  localparam logic [ALU_W-1:0] ALU_OR    = ALU_W'(3);
  localparam logic [ALU_W-1:0] ALU_AND   = ALU_W'(4);
  localparam logic [ALU_W-1:0] ALU_SLL   = ALU_W'(5);
  localparam logic [ALU_W-1:0] ALU_SRL   = ALU_W'(6);
  localparam logic [ALU_W-1:0] ALU_SRA   = ALU_W'(7);
  localparam logic [ALU_W-1:0] ALU_SLT   = ALU_W'(8);
  localparam logic [ALU_W-1:0] ALU_SLTU  = ALU_W'(9);
  localparam logic [ALU_W-1:0] ALU_PASSB = ALU_W'(10);

  // Counter only needs to hold 0..MEM_TIMEOUT-1; reaching the last value without ack traps.
  localparam int unsigned    TW       = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0]  TMO_LAST = (MEM_TIMEOUT > 0) ? TW'(MEM_TIMEOUT - 1) : '0;

  state_e             state_q, state_d;
  logic [31:0]        ir_q, ir_d;
  logic [CNT_W-1:0]   instret_q, instret_d;
  logic               illegal_q, illegal_d;
  logic               buserr_q, buserr_d;
  logic [TW-1:0]      tmo_q, tmo_d;

  logic [6:0]         opcode, funct7;
  logic [2:0]         funct3;
  logic               is_r, is_imath, is_load, is_store, is_branch;
  logic               is_jal, is_jalr, is_lui, is_auipc, known, r_bad, br_bad;
  logic               taken, tmo_hit;
  logic [2:0]         imm_sel;
  logic [ALU_W-1:0]   alu_op;

  assign opcode    = ir_q[6:0];
  assign funct3    = ir_q[14:12];
  assign funct7    = ir_q[31:25];
  assign is_r      = (opcode == OP_R);
  assign is_imath  = (opcode == OP_IMATH);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_lui    = (opcode == OP_LUI);
  assign is_auipc  = (opcode == OP_AUIPC);
  assign known     = is_r | is_imath | is_load | is_store | is_branch |
                     is_jal | is_jalr | is_lui | is_auipc;
  assign r_bad     = is_r && !((funct7 == 7'h00) ||
                     ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5))));
  assign br_bad    = is_branch && (funct3[2:1] == 2'b01);
  assign tmo_hit   = (MEM_TIMEOUT != 0) && (tmo_q == TMO_LAST);

  always_comb begin
    alu_op = ALU_ADD;
    if (is_r || is_imath) begin
      case (funct3)
        3'd0:    alu_op = (is_r && ir_q[30]) ? ALU_SUB : ALU_ADD;
        3'd1:    alu_op = ALU_SLL;
        3'd2:    alu_op = ALU_SLT;
        3'd3:    alu_op = ALU_SLTU;
        3'd4:    alu_op = ALU_XOR;
        3'd5:    alu_op = ir_q[30] ? ALU_SRA : ALU_SRL;
        3'd6:    alu_op = ALU_OR;
        default: alu_op = ALU_AND;
      endcase
    end else if (is_lui) begin
      alu_op = ALU_PASSB;
    end

    imm_sel = 3'd0;
    if (is_imath || is_load || is_jalr) imm_sel = 3'd1;
    else if (is_store)                  imm_sel = 3'd2;
    else if (is_branch)                 imm_sel = 3'd3;
    else if (is_jal)                    imm_sel = 3'd4;
    else if (is_lui || is_auipc)        imm_sel = 3'd5;

    case (funct3)
      3'd0:    taken = BrEq;
      3'd1:    taken = !BrEq;
      3'd4,
      3'd6:    taken = BrLt;
      default: taken = !BrLt;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    ir_d           = ir_q;
    instret_d      = instret_q;
    illegal_d      = illegal_q;
    buserr_d       = buserr_q;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_size       = 2'd0;
    mem_unsigned   = 1'b0;
    IRWrite        = 1'b0;
    PCWrite        = 1'b0;
    PCSel          = 1'b0;
    ImmSel         = 3'd0;
    ASel           = 1'b0;
    BSel           = 1'b0;
    ALUSel         = '0;
    BrUn           = 1'b0;
    RegWriteEnable = 1'b0;
    WBSel          = 2'd0;

    if (state_q inside {S_EXECUTE, S_MEM, S_WRITEBACK}) begin
      ImmSel = imm_sel;
      ASel   = is_auipc | is_jal | is_branch;
      BSel   = !is_r;
      ALUSel = alu_op;
    end

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          IRWrite = 1'b1;
          ir_d    = mem_rdata;
          state_d = S_DECODE;
        end else if (tmo_hit) begin
          state_d  = S_TRAP;
          buserr_d = 1'b1;
        end
      end
      S_DECODE: begin
        ImmSel = imm_sel;
        if (!known || r_bad) begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (is_branch) begin
          BrUn = funct3[2] & funct3[1];
          if (br_bad) begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end else begin
            PCWrite   = 1'b1;
            PCSel     = taken;
            instret_d = instret_q + CNT_W'(1);
            state_d   = S_FETCH;
          end
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_we       = is_store;
        mem_size     = funct3[1:0];
        mem_unsigned = is_load & funct3[2];
        if (mem_ack) begin
          if (is_store) begin
            PCWrite   = 1'b1;
            instret_d = instret_q + CNT_W'(1);
            state_d   = S_FETCH;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (tmo_hit) begin
          state_d  = S_TRAP;
          buserr_d = 1'b1;
        end
      end
      S_WRITEBACK: begin
        RegWriteEnable = 1'b1;
        WBSel          = is_load ? 2'd0 : ((is_jal || is_jalr) ? 2'd2 : 2'd1);
        PCWrite        = 1'b1;
        PCSel          = is_jal | is_jalr;
        instret_d      = instret_q + CNT_W'(1);
        state_d        = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    // Counter restarts on every state entry and only runs while waiting on the bus.
    if (state_d != state_q)                         tmo_d = '0;
    else if (state_q inside {S_FETCH, S_MEM})       tmo_d = tmo_q + 1'b1;
    else                                            tmo_d = '0;

    Inst         = ir_q;
    instret      = instret_q;
    illegal_inst = illegal_q;
    bus_error    = buserr_q;

    if (reset) begin
      mem_req        = 1'b0;
      mem_we         = 1'b0;
      mem_size       = 2'd0;
      mem_unsigned   = 1'b0;
      IRWrite        = 1'b0;
      PCWrite        = 1'b0;
      PCSel          = 1'b0;
      ImmSel         = 3'd0;
      ASel           = 1'b0;
      BSel           = 1'b0;
      ALUSel         = '0;
      BrUn           = 1'b0;
      RegWriteEnable = 1'b0;
      WBSel          = 2'd0;
      illegal_inst   = 1'b0;
      bus_error      = 1'b0;
      Inst           = '0;
      instret        = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
      buserr_q  <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
      buserr_q  <= buserr_d;
      tmo_q     <= tmo_d;
    end
  end

endmodule
